time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on each asynchronous input (minimum 2).
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, asynchronous, active-high
- sec_clk  input  1  1 Hz square wave from the clock divider; treated as asynchronous
- set_btn  input  1  debounced set button, active-high level
- inc_btn  input  1  debounced increment button, active-high level
- hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
- pm  output  1  PM indicator

Function
REQ-003 sec_clk, set_btn and inc_btn SHALL each pass through a SYNC_STAGES flop synchronizer.
REQ-004 Each synchronized input SHALL then feed a rising-edge detector that produces a one-cycle pulse: tick, set_p or inc_p.
REQ-005 Latency from an input rising edge to the resulting register update SHALL be SYNC_STAGES+1 clk edges.
REQ-006 The FSM SHALL have states RUN, SET_HR and SET_MIN. set_p SHALL advance the state RUN -> SET_HR -> SET_MIN -> RUN.
REQ-007 In RUN, each tick SHALL increment seconds, with the following carries:
- seconds 59 -> 00 and minutes increment
- minutes 59 -> 00 and hours increment
- hours 23 -> 00 (24 h mode)
REQ-008 In SET_HR and SET_MIN, tick SHALL be ignored and time SHALL be frozen.
REQ-009 In SET_HR, inc_p SHALL increment hours only, wrapping at the hours limit with no carry to any other field.
REQ-010 In SET_MIN, inc_p SHALL increment minutes only, wrapping 59 -> 00 with no carry and seconds unchanged.
REQ-011 On the SET_MIN -> RUN transition, seconds SHALL be cleared to 00.
REQ-012 In RUN, inc_p SHALL be ignored.
REQ-013 If set_p and tick occur in the same cycle, the state transition SHALL take effect and tick SHALL be dropped whenever the current state is RUN.
REQ-014 If set_p and inc_p occur in the same cycle, set_p SHALL win and inc_p SHALL be dropped.
REQ-015 All digits SHALL stay valid BCD (0-9) at all times, and the tens digits SHALL never exceed their field limits.
REQ-016 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-017 A button held high SHALL produce exactly one pulse per rising edge, with no auto-repeat.

Reset
REQ-018 Asserting rst SHALL asynchronously force the following, regardless of any in-progress set operation:
- state to RUN and mode to 00
- time to 00:00:00 (24 h) or 12:00:00 (12 h)
- pm to 0
- all synchronizer and edge-detector flops to 0
REQ-019 Because the edge-detector flops clear to 0, an input already high when rst releases SHALL generate one pulse after SYNC_STAGES+1 edges.

Configuration
REQ-020 The macro TWELVE_HOUR_EN SHALL select the hours format.
REQ-021 With TWELVE_HOUR_EN defined:
- hours SHALL count 12, 01 .. 11, then back to 12
- pm SHALL toggle when running time crosses 11:59:59 -> 12:00:00
- in SET_HR, inc_p from 11 -> 12 SHALL toggle pm
REQ-022 Without TWELVE_HOUR_EN, hours SHALL count 00-23 and pm SHALL be tied to 0.

Structure
REQ-023 Package clock_pkg SHALL hold the following shared definitions:
- state enum and mode encodings
- limit constants SEC_MAX=59, MIN_MAX=59, HR_MAX_24=23, HR_MIN_12=1, HR_MAX_12=12
- BCD digit typedef
REQ-024 One sub-module SHALL be used: sync_edge (synchronizer plus rising-edge detector), instantiated three times.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset (24 h): release rst -> digits 00:00:00, mode 00, pm 0; 3 sec_clk rising edges -> 00:00:03, each update exactly 3 clk edges after its edge.
- Rollover (24 h): preset 23:59:59 via set mode, then one tick -> 00:00:00. With TWELVE_HOUR_EN: 11:59:59 pm=0, then one tick -> 12:00:00 pm=1.
- Set flow: set_btn -> mode 01; 3 inc pulses from 22 -> 01 (24 h); set_btn -> mode 10; inc from 59 -> 00 with hours unchanged; set_btn -> mode 00 with seconds 00.
- Frozen time: in SET_HR, 5 ticks -> digits unchanged; inc_btn in RUN -> no change.
- Collisions: set_p with tick in RUN -> mode 01, seconds unchanged; set_p with inc_p in SET_HR -> mode 10, hours unchanged.
- Async reset mid-set: assert rst in SET_MIN between clk edges -> outputs reset immediately, before the next clk edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time_keeper clock: FSM states, mode codes,
// field limits, the BCD digit type and BCD increment helpers.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_HR  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN = 2'b10;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HR_MAX_24 = 23;
    localparam int HR_MIN_12 = 1;
    localparam int HR_MAX_12 = 12;

    function automatic bcd_t tens_of(input int v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t ones_of(input int v);
        return bcd_t'(v % 10);
    endfunction

    // Returns {wrapped, tens, ones}; wraps to 00 after the given maximum.
    function automatic logic [8:0] bcd_inc(input bcd_t t, input bcd_t o, input int max);
        if (t == tens_of(max) && o == ones_of(max)) begin
            return {1'b1, 4'd0, 4'd0};
        end else if (o == 4'd9) begin
            return {1'b0, t + 4'd1, 4'd0};
        end else begin
            return {1'b0, t, o + 4'd1};
        end
    endfunction

    // Returns {pm_toggle, tens, ones} for the 12, 01 .. 11, 12 hour sequence.
    function automatic logic [8:0] hr12_inc(input bcd_t t, input bcd_t o);
        if (t == tens_of(HR_MAX_12) && o == ones_of(HR_MAX_12)) begin
            return {1'b0, tens_of(HR_MIN_12), ones_of(HR_MIN_12)};
        end else if (t == tens_of(HR_MAX_12 - 1) && o == ones_of(HR_MAX_12 - 1)) begin
            return {1'b1, tens_of(HR_MAX_12), ones_of(HR_MAX_12)};
        end else if (o == 4'd9) begin
            return {1'b0, t + 4'd1, 4'd0};
        end else begin
            return {1'b0, t, o + 4'd1};
        end
    endfunction

endpackage

// File: rtl/time_keeper_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector (one-cycle pulse).
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain and previous-level flop for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/time_keeper.sv
// BCD time-of-day clock with RUN / SET_HR / SET_MIN modes.
// Define TWELVE_HOUR_EN for the 12-hour format with a PM indicator.
module time_keeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] mode,
    output logic       pm
);

`ifdef TWELVE_HOUR_EN
    localparam bcd_t HR_RST_T = tens_of(HR_MAX_12);
    localparam bcd_t HR_RST_O = ones_of(HR_MAX_12);
    localparam logic PM_EN    = 1'b1;
`else
    localparam bcd_t HR_RST_T = 4'd0;
    localparam bcd_t HR_RST_O = 4'd0;
    localparam logic PM_EN    = 1'b0;
`endif

    logic   w_tick, w_set_p, w_inc_p;
    state_t r_state, w_state_nxt;
    bcd_t   r_hr_t, r_hr_o, r_min_t, r_min_o, r_sec_t, r_sec_o;
    bcd_t   w_hr_t_nxt, w_hr_o_nxt, w_min_t_nxt, w_min_o_nxt, w_sec_t_nxt, w_sec_o_nxt;
    logic   r_pm, w_pm_nxt;
    logic [8:0] w_sec_inc, w_min_inc, w_hr_inc;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .i_clk(clk), .i_rst(rst), .i_async(sec_clk), .o_pulse(w_tick));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
        .i_clk(clk), .i_rst(rst), .i_async(set_btn), .o_pulse(w_set_p));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
        .i_clk(clk), .i_rst(rst), .i_async(inc_btn), .o_pulse(w_inc_p));

    assign w_sec_inc = bcd_inc(r_sec_t, r_sec_o, SEC_MAX);
    assign w_min_inc = bcd_inc(r_min_t, r_min_o, MIN_MAX);
`ifdef TWELVE_HOUR_EN
    assign w_hr_inc  = hr12_inc(r_hr_t, r_hr_o);
`else
    assign w_hr_inc  = bcd_inc(r_hr_t, r_hr_o, HR_MAX_24);
`endif

    // Next-state and next-time logic; set_p always wins over tick and inc_p
    always_comb begin
        w_state_nxt = r_state;
        w_hr_t_nxt  = r_hr_t;
        w_hr_o_nxt  = r_hr_o;
        w_min_t_nxt = r_min_t;
        w_min_o_nxt = r_min_o;
        w_sec_t_nxt = r_sec_t;
        w_sec_o_nxt = r_sec_o;
        w_pm_nxt    = r_pm;
        case (r_state)
            ST_RUN: begin
                if (w_set_p) begin
                    w_state_nxt = ST_SET_HR;
                end else if (w_tick) begin
                    {w_sec_t_nxt, w_sec_o_nxt} = w_sec_inc[7:0];
                    if (w_sec_inc[8]) begin
                        {w_min_t_nxt, w_min_o_nxt} = w_min_inc[7:0];
                        if (w_min_inc[8]) begin
                            {w_hr_t_nxt, w_hr_o_nxt} = w_hr_inc[7:0];
                            w_pm_nxt = r_pm ^ (w_hr_inc[8] & PM_EN);
                        end else begin
                            w_pm_nxt = r_pm;
                        end
                    end else begin
                        w_pm_nxt = r_pm;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET_HR: begin
                if (w_set_p) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_inc_p) begin
                    {w_hr_t_nxt, w_hr_o_nxt} = w_hr_inc[7:0];
                    w_pm_nxt = r_pm ^ (w_hr_inc[8] & PM_EN);
                end else begin
                    w_state_nxt = ST_SET_HR;
                end
            end
            ST_SET_MIN: begin
                if (w_set_p) begin
                    w_state_nxt = ST_RUN;
                    w_sec_t_nxt = 4'd0;
                    w_sec_o_nxt = 4'd0;
                end else if (w_inc_p) begin
                    {w_min_t_nxt, w_min_o_nxt} = w_min_inc[7:0];
                end else begin
                    w_state_nxt = ST_SET_MIN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Time digit and PM registers; these drive the outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hr_t  <= HR_RST_T;
            r_hr_o  <= HR_RST_O;
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_pm    <= 1'b0;
        end else begin
            r_hr_t  <= w_hr_t_nxt;
            r_hr_o  <= w_hr_o_nxt;
            r_min_t <= w_min_t_nxt;
            r_min_o <= w_min_o_nxt;
            r_sec_t <= w_sec_t_nxt;
            r_sec_o <= w_sec_o_nxt;
            r_pm    <= w_pm_nxt;
        end
    end

    assign hr_tens  = r_hr_t;
    assign hr_ones  = r_hr_o;
    assign min_tens = r_min_t;
    assign min_ones = r_min_o;
    assign sec_tens = r_sec_t;
    assign sec_ones = r_sec_o;
    assign mode     = r_state;
    assign pm       = r_pm;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper (24 h default, 12 h with TWELVE_HOUR_EN).
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_clk = 1'b0;
    logic       set_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] mode;
    logic       pm;
    logic [23:0] tk_time;

    int checks = 0;
    int errors = 0;

`ifdef TWELVE_HOUR_EN
    localparam logic [23:0] T_RST = 24'h120000;
`else
    localparam logic [23:0] T_RST = 24'h000000;
`endif

    time_keeper #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sec_clk(sec_clk), .set_btn(set_btn), .inc_btn(inc_btn),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .pm(pm));

    assign tk_time = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    always #10 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Raise the selected inputs, hold them well past the update, then release.
    task automatic pulse(input logic do_tick, input logic do_set, input logic do_inc);
        @(negedge clk);
        sec_clk = do_tick;
        set_btn = do_set;
        inc_btn = do_inc;
        repeat (5) @(posedge clk);
        @(negedge clk);
        sec_clk = 1'b0;
        set_btn = 1'b0;
        inc_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #35;
        checks++;
        if (tk_time !== T_RST || mode !== 2'b00 || pm !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold time=%h mode=%b pm=%b exp time=%h mode=00 pm=0", tk_time, mode, pm, T_RST);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (tk_time !== T_RST || mode !== 2'b00 || pm !== 1'b0) begin
            errors++;
            $display("FAIL reset_release time=%h mode=%b pm=%b exp time=%h", tk_time, mode, pm, T_RST);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            sec_clk = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (tk_time !== T_RST + 24'(i - 1)) begin
                errors++;
                $display("FAIL tick_early%0d time=%h exp=%h", i, tk_time, T_RST + 24'(i - 1));
            end
            @(posedge clk);
            #1;
            checks++;
            if (tk_time !== T_RST + 24'(i)) begin
                errors++;
                $display("FAIL tick_latency%0d time=%h exp=%h", i, tk_time, T_RST + 24'(i));
            end
            repeat (2) @(posedge clk);
            @(negedge clk);
            sec_clk = 1'b0;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic test_set_flow();
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b01) begin
            errors++;
            $display("FAIL set_enter_hr mode=%b exp=01", mode);
        end
        repeat (22) pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (tk_time !== 24'h220003) begin
            errors++;
            $display("FAIL set_hr_22 time=%h exp=220003", tk_time);
        end
        repeat (3) pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (tk_time !== 24'h010003) begin
            errors++;
            $display("FAIL set_hr_wrap time=%h exp=010003", tk_time);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b10) begin
            errors++;
            $display("FAIL set_enter_min mode=%b exp=10", mode);
        end
        repeat (59) pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (tk_time !== 24'h015903) begin
            errors++;
            $display("FAIL set_min_59 time=%h exp=015903", tk_time);
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (tk_time !== 24'h010003) begin
            errors++;
            $display("FAIL set_min_wrap time=%h exp=010003", tk_time);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b00 || tk_time !== 24'h010000) begin
            errors++;
            $display("FAIL set_exit mode=%b time=%h exp mode=00 time=010000", mode, tk_time);
        end
    endtask

    task automatic test_frozen();
        pulse(1'b0, 1'b1, 1'b0);
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'b01 || tk_time !== 24'h010000) begin
            errors++;
            $display("FAIL frozen_ticks mode=%b time=%h exp mode=01 time=010000", mode, tk_time);
        end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (mode !== 2'b00 || tk_time !== 24'h010000) begin
            errors++;
            $display("FAIL run_inc_ignored mode=%b time=%h exp mode=00 time=010000", mode, tk_time);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (tk_time !== 24'h010001) begin
            errors++;
            $display("FAIL run_tick time=%h exp=010001", tk_time);
        end
    endtask

    task automatic test_collision();
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b01 || tk_time !== 24'h010001) begin
            errors++;
            $display("FAIL set_tick_collide mode=%b time=%h exp mode=01 time=010001", mode, tk_time);
        end
        pulse(1'b0, 1'b1, 1'b1);
        checks++;
        if (mode !== 2'b10 || tk_time !== 24'h010001) begin
            errors++;
            $display("FAIL set_inc_collide mode=%b time=%h exp mode=10 time=010001", mode, tk_time);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b00 || tk_time !== 24'h010000) begin
            errors++;
            $display("FAIL collide_exit mode=%b time=%h exp mode=00 time=010000", mode, tk_time);
        end
    endtask

    // Presets hh:59:00 via set mode, then runs 59 ticks and one rollover tick.
    task automatic test_rollover(input int hr_incs, input logic [23:0] exp_pre,
                                 input logic [23:0] exp_post, input logic exp_pm);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (hr_incs) pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (59) pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (59) pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (tk_time !== exp_pre || pm !== 1'b0) begin
            errors++;
            $display("FAIL rollover_pre time=%h pm=%b exp time=%h pm=0", tk_time, pm, exp_pre);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (tk_time !== exp_post || pm !== exp_pm) begin
            errors++;
            $display("FAIL rollover time=%h pm=%b exp time=%h pm=%b", tk_time, pm, exp_post, exp_pm);
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'b10) begin
            errors++;
            $display("FAIL async_pre mode=%b exp=10", mode);
        end
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (tk_time !== T_RST || mode !== 2'b00 || pm !== 1'b0) begin
            errors++;
            $display("FAIL async_reset time=%h mode=%b pm=%b exp time=%h mode=00 pm=0", tk_time, mode, pm, T_RST);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
`ifdef TWELVE_HOUR_EN
        test_rollover(11, 24'h115959, 24'h120000, 1'b1);
`else
        test_set_flow();
        test_frozen();
        test_collision();
        test_rollover(22, 24'h235959, 24'h000000, 1'b0);
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
